// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared types, twiddle generator and saturation helper for fft_stream
package fft_pkg;

   localparam int  DEF_N_POINTS    = 16;
   localparam int  DEF_P_LANES     = 4;
   localparam int  DEF_INPUT_WIDTH = 8;
   localparam int  DEF_LOG2N       = $clog2(DEF_N_POINTS);
   localparam int  DEF_GW          = DEF_INPUT_WIDTH + 2 * DEF_LOG2N;
   localparam real PI              = 3.14159265358979323846;

   typedef struct packed {
      logic signed [DEF_INPUT_WIDTH-1:0] re;
      logic signed [DEF_INPUT_WIDTH-1:0] im;
   } cplx_t;

   typedef struct packed {
      logic signed [DEF_GW-1:0] re;
      logic signed [DEF_GW-1:0] im;
   } gcplx_t;

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_FULL = 1'b1
   } fill_state_e;

   // Rounded cos/sin of 2*pi*k/n with frac fractional bits; elaboration-time only.
   function automatic int twiddle(input int k, input int n, input int frac, input bit sine);
      real ang;
      real v;
      real scale;
      scale = 1.0;
      for (int i = 0; i < frac; i++) scale = scale * 2.0;
      ang = 2.0 * PI * real'(k) / real'(n);
      v   = (sine ? $sin(ang) : $cos(ang)) * scale;
      return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
   endfunction

   function automatic longint saturate(input longint v, input int ow);
      longint hi;
      longint lo;
      hi = (longint'(1) <<< (ow - 1)) - 1;
      lo = -hi - 1;
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/fft_stream_if.sv
// rtl/fft_stream_if.sv - sample input and result output handshakes of fft_stream
interface fft_stream_if #(
   parameter int N_POINTS     = fft_pkg::DEF_N_POINTS,
   parameter int P_LANES      = fft_pkg::DEF_P_LANES,
   parameter int INPUT_WIDTH  = fft_pkg::DEF_INPUT_WIDTH,
   parameter int OUTPUT_WIDTH = INPUT_WIDTH + 4
);
   logic                                         i_valid;
   logic                                         o_ready;
   logic [P_LANES-1:0][1:0][INPUT_WIDTH-1:0]     i_data;
   logic                                         i_inverse;
   logic                                         i_flush;
   logic                                         o_valid;
   logic                                         i_ready;
   logic [N_POINTS-1:0][1:0][OUTPUT_WIDTH-1:0]   o_data;
   logic                                         o_inverse;
   logic                                         o_sat;

   modport master (
      output i_valid, i_data, i_inverse, i_flush, i_ready,
      input  o_ready, o_valid, o_data, o_inverse, o_sat
   );

   modport slave (
      input  i_valid, i_data, i_inverse, i_flush, i_ready,
      output o_ready, o_valid, o_data, o_inverse, o_sat
   );
endinterface

// File: rtl/fft_core.sv
// rtl/fft_core.sv - combinational recursive radix-2 decimation-in-time forward FFT
module fft_core
   import fft_pkg::*;
#(
   parameter int N = 16,
   parameter int W = 16
) (
   input  logic [N-1:0][1:0][W-1:0] i_x,
   output logic [N-1:0][1:0][W-1:0] o_x
);

   generate
      if (N == 1) begin : g_leaf
         assign o_x = i_x;
      end else begin : g_split
         localparam int H  = N / 2;
         localparam int PW = 2 * W + 3;

         logic [H-1:0][1:0][W-1:0] w_even_in;
         logic [H-1:0][1:0][W-1:0] w_odd_in;
         logic [H-1:0][1:0][W-1:0] w_even;
         logic [H-1:0][1:0][W-1:0] w_odd;

         for (genvar j = 0; j < H; j++) begin : g_dec
            assign w_even_in[j] = i_x[2*j];
            assign w_odd_in[j]  = i_x[2*j+1];
         end

         fft_core #(.N(H), .W(W)) u_even (.i_x(w_even_in), .o_x(w_even));
         fft_core #(.N(H), .W(W)) u_odd  (.i_x(w_odd_in),  .o_x(w_odd));

         // Twiddles carry W fractional bits, so the product is rescaled by >>> W.
         for (genvar k = 0; k < H; k++) begin : g_bfly
            localparam int C = twiddle(k, N, W, 1'b0);
            localparam int S = twiddle(k, N, W, 1'b1);

            logic signed [PW-1:0] w_or;
            logic signed [PW-1:0] w_oi;
            logic signed [PW-1:0] w_pr;
            logic signed [PW-1:0] w_pi;
            logic        [W-1:0]  w_tr;
            logic        [W-1:0]  w_ti;

            assign w_or = PW'($signed(w_odd[k][0]));
            assign w_oi = PW'($signed(w_odd[k][1]));
            assign w_pr = w_or * PW'(C) + w_oi * PW'(S);
            assign w_pi = w_oi * PW'(C) - w_or * PW'(S);
            assign w_tr = W'(w_pr >>> W);
            assign w_ti = W'(w_pi >>> W);

            assign o_x[k][0]   = w_even[k][0] + w_tr;
            assign o_x[k][1]   = w_even[k][1] + w_ti;
            assign o_x[k+H][0] = w_even[k][0] - w_tr;
            assign o_x[k+H][1] = w_even[k][1] - w_ti;
         end
      end
   endgenerate

endmodule

// File: rtl/fft_stream.sv
// rtl/fft_stream.sv - frame collector, FFT/IFFT mode swap and held saturating result register
module fft_stream #(
   parameter int N_POINTS     = fft_pkg::DEF_N_POINTS,
   parameter int P_LANES      = fft_pkg::DEF_P_LANES,
   parameter int INPUT_WIDTH  = fft_pkg::DEF_INPUT_WIDTH,
   parameter int OUTPUT_WIDTH = INPUT_WIDTH + 4,
   parameter int OUT_SHIFT    = 3
) (
   input  logic        clk,
   input  logic        rst_async_n,
   fft_stream_if.slave bus
);
   import fft_pkg::*;

   localparam int LOG2N = $clog2(N_POINTS);
   localparam int GW    = INPUT_WIDTH + 2 * LOG2N;
   localparam int BEATS = N_POINTS / P_LANES;
   localparam int KW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(BEATS - 1);

   fill_state_e                                r_state;
   fill_state_e                                w_state_nxt;
   logic [KW-1:0]                              r_k;
   logic                                       r_mode;
   logic [BEATS-1:0][P_LANES-1:0][1:0][GW-1:0] r_buf;
   logic                                       r_ovalid;
   logic [N_POINTS-1:0][1:0][OUTPUT_WIDTH-1:0] r_odata;
   logic                                       r_oinv;
   logic                                       r_osat;

   logic [P_LANES-1:0][1:0][GW-1:0]            w_beat;
   logic [N_POINTS-1:0][1:0][GW-1:0]           w_core_in;
   logic [N_POINTS-1:0][1:0][GW-1:0]           w_core;
   logic [N_POINTS-1:0][1:0][OUTPUT_WIDTH-1:0] w_odata;
   logic [2*N_POINTS-1:0]                      w_clip;
   logic                                       w_ready;
   logic                                       w_accept;
   logic                                       w_last;
   logic                                       w_xfer;
   logic                                       w_inv_now;
   logic                                       w_sat;

   function automatic logic [OUTPUT_WIDTH:0] scale_clip(input logic [GW-1:0] v);
      longint sh;
      longint cl;
      sh = longint'($signed(v) >>> OUT_SHIFT);
      cl = saturate(sh, OUTPUT_WIDTH);
      return {cl != sh, OUTPUT_WIDTH'(cl)};
   endfunction

   assign w_accept  = bus.i_valid && w_ready && !bus.i_flush;
   assign w_last    = (r_k == K_LAST);
   assign w_xfer    = (r_state == ST_FULL) && (!r_ovalid || bus.i_ready);
   assign w_inv_now = (r_k == '0) ? bus.i_inverse : r_mode;

   always_ff @(posedge clk or negedge rst_async_n) begin
      if (!rst_async_n) r_state <= ST_FILL;
      else              r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_FILL: if (w_accept && w_last) w_state_nxt = ST_FULL;
         ST_FULL: if (w_xfer)             w_state_nxt = ST_FILL;
         default:                         w_state_nxt = ST_FILL;
      endcase
   end

   always_comb begin
      w_ready = (r_state == ST_FILL);
   end

   // Inverse mode stores (im, re) so the forward core yields a swapped IFFT.
   generate
      for (genvar i = 0; i < P_LANES; i++) begin : g_lane
         logic [GW-1:0] w_re;
         logic [GW-1:0] w_im;
         assign w_re         = GW'($signed(bus.i_data[i][0]));
         assign w_im         = GW'($signed(bus.i_data[i][1]));
         assign w_beat[i][0] = w_inv_now ? w_im : w_re;
         assign w_beat[i][1] = w_inv_now ? w_re : w_im;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_async_n) begin
      if (!rst_async_n) begin
         r_k    <= '0;
         r_mode <= 1'b0;
      end else if (bus.i_flush) begin
         r_k <= '0;
      end else if (w_accept) begin
         if (r_k == '0) r_mode <= bus.i_inverse;
         r_k <= w_last ? '0 : r_k + KW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) r_buf[r_k] <= w_beat;
   end

   assign w_core_in = r_buf;

   fft_core #(.N(N_POINTS), .W(GW)) u_core (
      .i_x (w_core_in),
      .o_x (w_core)
   );

   generate
      for (genvar b = 0; b < N_POINTS; b++) begin : g_out
         logic [OUTPUT_WIDTH:0] w_re;
         logic [OUTPUT_WIDTH:0] w_im;
         assign w_re          = scale_clip(r_mode ? w_core[b][1] : w_core[b][0]);
         assign w_im          = scale_clip(r_mode ? w_core[b][0] : w_core[b][1]);
         assign w_odata[b][0] = w_re[OUTPUT_WIDTH-1:0];
         assign w_odata[b][1] = w_im[OUTPUT_WIDTH-1:0];
         assign w_clip[2*b]   = w_re[OUTPUT_WIDTH];
         assign w_clip[2*b+1] = w_im[OUTPUT_WIDTH];
      end
   endgenerate

   assign w_sat = |w_clip;

   always_ff @(posedge clk or negedge rst_async_n) begin
      if (!rst_async_n) begin
         r_ovalid <= 1'b0;
         r_odata  <= '0;
         r_oinv   <= 1'b0;
         r_osat   <= 1'b0;
      end else if (w_xfer) begin
         r_ovalid <= 1'b1;
         r_odata  <= w_odata;
         r_oinv   <= r_mode;
         r_osat   <= w_sat;
      end else if (r_ovalid && bus.i_ready) begin
         r_ovalid <= 1'b0;
      end
   end

   assign bus.o_ready   = w_ready;
   assign bus.o_valid   = r_ovalid;
   assign bus.o_data    = r_odata;
   assign bus.o_inverse = r_oinv;
   assign bus.o_sat     = r_osat;

endmodule

// File: tb/tb_fft_stream.sv
// tb/tb_fft_stream.sv - directed-vector bench for fft_stream, default and narrow-output instances
module tb_fft_stream;

   localparam int N    = 16;
   localparam int P    = 4;
   localparam int IW   = 8;
   localparam int OW   = 12;
   localparam int OW_S = 8;

   logic clk         = 1'b0;
   logic rst_async_n = 1'b1;
   always #5 clk = ~clk;

   logic                        tb_valid   = 1'b0;
   logic                        tb_inverse = 1'b0;
   logic                        tb_flush   = 1'b0;
   logic                        tb_ready   = 1'b1;
   logic [P-1:0][1:0][IW-1:0]   tb_data    = '0;

   int n_cmp = 0;
   int n_err = 0;
   int f_re [N];
   int f_im [N];

   fft_stream_if #(.N_POINTS(N), .P_LANES(P), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW))   if_a ();
   fft_stream_if #(.N_POINTS(N), .P_LANES(P), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW_S)) if_s ();

   assign if_a.i_valid   = tb_valid;
   assign if_a.i_data    = tb_data;
   assign if_a.i_inverse = tb_inverse;
   assign if_a.i_flush   = tb_flush;
   assign if_a.i_ready   = tb_ready;
   assign if_s.i_valid   = tb_valid;
   assign if_s.i_data    = tb_data;
   assign if_s.i_inverse = tb_inverse;
   assign if_s.i_flush   = tb_flush;
   assign if_s.i_ready   = tb_ready;

   fft_stream #(.N_POINTS(N), .P_LANES(P), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .OUT_SHIFT(3)) u_dut (
      .clk         (clk),
      .rst_async_n (rst_async_n),
      .bus         (if_a)
   );

   fft_stream #(.N_POINTS(N), .P_LANES(P), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW_S), .OUT_SHIFT(3)) u_dut_sat (
      .clk         (clk),
      .rst_async_n (rst_async_n),
      .bus         (if_s)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int bin_a(input int b, input int c);
      return int'($signed(if_a.o_data[4'(b)][c[0]]));
   endfunction

   function automatic int bin_s(input int b, input int c);
      return int'($signed(if_s.o_data[4'(b)][c[0]]));
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_zero();
      for (int i = 0; i < N; i++) begin
         f_re[4'(i)] = 0;
         f_im[4'(i)] = 0;
      end
   endtask

   task automatic set_const_re(input int v);
      for (int i = 0; i < N; i++) f_re[4'(i)] = v;
   endtask

   task automatic send_beat(input int b, input bit inv);
      int w;
      tb_valid   = 1'b1;
      tb_inverse = inv;
      for (int i = 0; i < P; i++) begin
         tb_data[2'(i)][0] = IW'(f_re[4'(b * P + i)]);
         tb_data[2'(i)][1] = IW'(f_im[4'(b * P + i)]);
      end
      w = 0;
      while (!if_a.o_ready && w < 50) begin
         tick();
         w++;
      end
      check("beat_ready", int'(if_a.o_ready), 1);
      tick();
      tb_valid = 1'b0;
   endtask

   task automatic send_frame(input bit inv);
      for (int b = 0; b < N / P; b++) send_beat(b, inv);
   endtask

   task automatic wait_valid(input string tag);
      int w;
      w = 0;
      while (!if_a.o_valid && w < 50) begin
         tick();
         w++;
      end
      check(tag, int'(if_a.o_valid), 1);
   endtask

   task automatic check_all_bins(input string tag, input int re0, input int re_rest);
      for (int b = 0; b < N; b++) begin
         check($sformatf("%s_bin%0d_re", tag, b), bin_a(b, 0), (b == 0) ? re0 : re_rest);
         check($sformatf("%s_bin%0d_im", tag, b), bin_a(b, 1), 0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int bad;

      #2 rst_async_n = 1'b0;
      #1;
      check("rst_o_valid",   int'(if_a.o_valid),   0);
      check("rst_o_ready",   int'(if_a.o_ready),   1);
      check("rst_o_sat",     int'(if_a.o_sat),     0);
      check("rst_o_inverse", int'(if_a.o_inverse), 0);
      check("rst_o_data_nz", int'(if_a.o_data != '0), 0);
      repeat (2) @(posedge clk);
      #3 rst_async_n = 1'b1;
      tick();

      // DC frame: all real 0x40.
      set_zero();
      set_const_re(64);
      send_frame(1'b0);
      check("dc_valid_at_last", int'(if_a.o_valid), 0);
      check("dc_ready_full",    int'(if_a.o_ready), 0);
      tick();
      check("dc_valid_next", int'(if_a.o_valid), 1);
      check_all_bins("dc", 128, 0);
      check("dc_sat", int'(if_a.o_sat),     0);
      check("dc_inv", int'(if_a.o_inverse), 0);
      check("dc_ready_back", int'(if_a.o_ready), 1);
      tick();
      check("dc_valid_drop", int'(if_a.o_valid), 0);
      check("dc_data_held",  bin_a(0, 0), 128);

      // Impulse 0x7F at x[0].
      set_zero();
      f_re[0] = 127;
      send_frame(1'b0);
      wait_valid("imp_valid");
      check_all_bins("imp", 15, 15);

      // x[1] = 0x40: forward then inverse.
      set_zero();
      f_re[1] = 64;
      send_frame(1'b0);
      wait_valid("fwd_valid");
      check("fwd_bin4_re", bin_a(4, 0), 0);
      check("fwd_bin4_im", bin_a(4, 1), -8);
      check("fwd_bin0_re", bin_a(0, 0), 8);
      check("fwd_inv",     int'(if_a.o_inverse), 0);
      send_frame(1'b1);
      wait_valid("inv_valid");
      check("inv_bin4_re", bin_a(4, 0), 0);
      check("inv_bin4_im", bin_a(4, 1), 8);
      check("inv_bin0_re", bin_a(0, 0), 8);
      check("inv_bin0_im", bin_a(0, 1), 0);
      check("inv_flag",    int'(if_a.o_inverse), 1);
      tick();

      // Backpressure: frame A held while frame B fills.
      tb_ready = 1'b0;
      set_zero();
      set_const_re(64);
      send_frame(1'b0);
      wait_valid("bp_a_valid");
      check("bp_a_bin0", bin_a(0, 0), 128);
      set_zero();
      f_re[0] = 127;
      send_beat(0, 1'b0);
      send_beat(1, 1'b0);
      send_beat(2, 1'b0);
      check("bp_ready_b3", int'(if_a.o_ready), 1);
      send_beat(3, 1'b0);
      check("bp_ready_low", int'(if_a.o_ready), 0);
      bad = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (!if_a.o_valid || bin_a(0, 0) != 128 || bin_a(1, 0) != 0 || if_a.o_ready) bad++;
      end
      check("bp_hold_stable", bad, 0);
      tb_ready = 1'b1;
      tick();
      check("bp_b_valid", int'(if_a.o_valid), 1);
      check("bp_b_bin0",  bin_a(0, 0), 15);
      check("bp_b_bin3",  bin_a(3, 0), 15);
      check("bp_ready",   int'(if_a.o_ready), 1);
      tick();
      check("bp_b_drop",  int'(if_a.o_valid), 0);

      // Saturation: all real 0x80, held for the reset test.
      tb_ready = 1'b0;
      set_zero();
      set_const_re(-128);
      send_frame(1'b0);
      wait_valid("sat_valid");
      check("sat_bin0",      bin_s(0, 0), -128);
      check("sat_flag",      int'(if_s.o_sat), 1);
      check("sat_bin1",      bin_s(1, 0), 0);
      check("wide_bin0",     bin_a(0, 0), -256);
      check("wide_sat_flag", int'(if_a.o_sat), 0);

      // Asynchronous reset after two beats, with a result held.
      set_zero();
      set_const_re(64);
      send_beat(0, 1'b0);
      send_beat(1, 1'b0);
      check("prerst_valid", int'(if_a.o_valid), 1);
      #2 rst_async_n = 1'b0;
      #1;
      check("arst_o_valid", int'(if_a.o_valid), 0);
      check("arst_o_data",  int'(if_a.o_data != '0), 0);
      check("arst_o_sat",   int'(if_s.o_sat), 0);
      check("arst_o_ready", int'(if_a.o_ready), 1);
      #3 rst_async_n = 1'b1;
      tb_ready = 1'b1;
      tick();
      set_zero();
      f_re[1] = 64;
      send_frame(1'b0);
      wait_valid("rst_fresh_valid");
      check("rst_fresh_bin0", bin_a(0, 0), 8);
      check("rst_fresh_bin4_re", bin_a(4, 0), 0);
      check("rst_fresh_bin4_im", bin_a(4, 1), -8);

      // Flush after three beats; the flush-cycle beat must be ignored.
      set_zero();
      set_const_re(64);
      send_beat(0, 1'b0);
      send_beat(1, 1'b0);
      send_beat(2, 1'b0);
      tb_flush = 1'b1;
      tb_valid = 1'b1;
      tick();
      tb_flush = 1'b0;
      tb_valid = 1'b0;
      check("flush_no_valid", int'(if_a.o_valid), 0);
      check("flush_ready",    int'(if_a.o_ready), 1);
      set_zero();
      f_re[0] = 127;
      send_frame(1'b0);
      wait_valid("flush_fresh_valid");
      check_all_bins("flush_fresh", 15, 15);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
